trace_packet_arbiter: RTL and testbench

//   Merges NUM_CH trace-debugger packet-word streams (one per traced core) into one output stream.

---
 rtl/trace_packet_arbiter.sv | 139 +++++++++++++
 tb/tb_trace_packet_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_packet_arbiter.sv
// Merges NUM_CH non-stallable trace word streams through per-channel FIFOs into one
// round-robin arbitrated valid/ready output register; overflowing words are dropped and counted.
module trace_packet_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      flush_i,
  input  logic [NUM_CH*WORD_W-1:0]  ch_word_i,
  input  logic [NUM_CH-1:0]         ch_valid_i,
  output logic [WORD_W-1:0]         packet_word_o,
  output logic [CH_W-1:0]           packet_ch_o,
  output logic                      packet_valid_o,
  input  logic                      packet_ready_i,
  output logic [NUM_CH-1:0]         fifo_empty_o,
  output logic [NUM_CH-1:0]         overflow_o,
  input  logic [NUM_CH-1:0]         overflow_clr_i,
  output logic [NUM_CH*CNT_W-1:0]   drop_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WORD_W-1:0] mem [NUM_CH][FIFO_DEPTH];
  logic [AW:0]       wr_ptr [NUM_CH];
  logic [AW:0]       rd_ptr [NUM_CH];
  logic [CNT_W-1:0]  drop_cnt [NUM_CH];
  logic [CNT_W-1:0]  cnt_base [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt [NUM_CH];

  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] drop;
  logic [NUM_CH-1:0] ovf_nxt;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   cand;
  logic              grant_vld;
  logic              load;
  logic [WORD_W-1:0] rd_data;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      empty[c] = (wr_ptr[c] == rd_ptr[c]);
      full[c]  = (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]) && (wr_ptr[c][AW] != rd_ptr[c][AW]);
    end
  end

  // Round-robin search begins one past the last channel that actually popped.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((int'(last_grant) + i) % NUM_CH);
      if (!grant_vld && !empty[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
  end

  assign load    = !packet_valid_o || packet_ready_i;
  assign rd_data = mem[grant][rd_ptr[grant][AW-1:0]];

  // A full FIFO still accepts a word when it pops in the same cycle; the clear
  // is applied before a same-cycle drop so the drop is never lost.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      pop[c]      = !flush_i && load && grant_vld && (grant == CH_W'(c));
      push[c]     = !flush_i && en_i && ch_valid_i[c] && (!full[c] || pop[c]);
      drop[c]     = !flush_i && en_i && ch_valid_i[c] && full[c] && !pop[c];
      cnt_base[c] = overflow_clr_i[c] ? '0 : drop_cnt[c];
      cnt_nxt[c]  = (drop[c] && (cnt_base[c] != '1)) ? cnt_base[c] + CNT_W'(1) : cnt_base[c];
      ovf_nxt[c]  = (overflow_o[c] && !overflow_clr_i[c]) || drop[c];
    end
  end

  always_comb begin
    drop_cnt_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      drop_cnt_o[c*CNT_W +: CNT_W] = drop_cnt[c];
    end
  end

  assign fifo_empty_o = empty;

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem[c][wr_ptr[c][AW-1:0]] <= ch_word_i[c*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c]   <= '0;
        rd_ptr[c]   <= '0;
        drop_cnt[c] <= '0;
      end
      overflow_o     <= '0;
      packet_valid_o <= 1'b0;
      packet_word_o  <= '0;
      packet_ch_o    <= '0;
      last_grant     <= CH_W'(NUM_CH - 1);
    end else begin
      overflow_o <= ovf_nxt;
      for (int c = 0; c < NUM_CH; c++) drop_cnt[c] <= cnt_nxt[c];
      if (flush_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
          wr_ptr[c] <= '0;
          rd_ptr[c] <= '0;
        end
        packet_valid_o <= 1'b0;
        last_grant     <= CH_W'(NUM_CH - 1);
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (push[c]) wr_ptr[c] <= wr_ptr[c] + (AW+1)'(1);
          if (pop[c])  rd_ptr[c] <= rd_ptr[c] + (AW+1)'(1);
        end
        if (load) begin
          packet_valid_o <= grant_vld;
          if (grant_vld) begin
            packet_word_o <= rd_data;
            packet_ch_o   <= grant;
            last_grant    <= grant;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_trace_packet_arbiter.sv
// Bench for trace_packet_arbiter: directed scenarios plus random traffic, all
// compared every cycle against a queue-based model of the arbiter.
module tb_trace_packet_arbiter;

  localparam int NUM_CH     = 4;
  localparam int WORD_W     = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 8;
  localparam int CH_W       = 2;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst, en, flush, ready;
  logic [NUM_CH*WORD_W-1:0] words;
  logic [NUM_CH-1:0]        vld, clr;
  logic [WORD_W-1:0]        packet_word;
  logic [CH_W-1:0]          packet_ch;
  logic                     packet_valid;
  logic [NUM_CH-1:0]        fifo_empty, overflow;
  logic [NUM_CH*CNT_W-1:0]  drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [WORD_W-1:0] q [NUM_CH][$];
  logic              m_valid;
  logic [WORD_W-1:0] m_word;
  int                m_ch;
  int                m_last;
  logic              m_ovf [NUM_CH];
  int                m_cnt [NUM_CH];

  trace_packet_arbiter #(
    .NUM_CH(NUM_CH), .WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush),
    .ch_word_i(words), .ch_valid_i(vld),
    .packet_word_o(packet_word), .packet_ch_o(packet_ch),
    .packet_valid_o(packet_valid), .packet_ready_i(ready),
    .fifo_empty_o(fifo_empty), .overflow_o(overflow),
    .overflow_clr_i(clr), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Next-state of the model for the inputs currently applied.
  task automatic model_step();
    int g;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        q[c].delete(); m_ovf[c] = 1'b0; m_cnt[c] = 0;
      end
      m_valid = 1'b0; m_word = '0; m_ch = 0; m_last = NUM_CH - 1;
      return;
    end
    if (flush) begin
      for (int c = 0; c < NUM_CH; c++) begin
        q[c].delete();
        if (clr[c]) begin m_ovf[c] = 1'b0; m_cnt[c] = 0; end
      end
      m_valid = 1'b0; m_last = NUM_CH - 1;
      return;
    end
    if (!m_valid || ready) begin
      g = -1;
      for (int i = 1; i <= NUM_CH; i++) begin
        int k;
        k = (m_last + i) % NUM_CH;
        if (g < 0 && q[k].size() > 0) g = k;
      end
      if (g >= 0) begin
        m_word = q[g].pop_front(); m_ch = g; m_valid = 1'b1; m_last = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (clr[c]) begin m_ovf[c] = 1'b0; m_cnt[c] = 0; end
      if (en && vld[c]) begin
        if (q[c].size() < FIFO_DEPTH) q[c].push_back(words[c*WORD_W +: WORD_W]);
        else begin
          m_ovf[c] = 1'b1;
          if (m_cnt[c] < CNT_MAX) m_cnt[c]++;
        end
      end
    end
  endtask

  task automatic compare();
    logic [NUM_CH-1:0]       e_empty, e_ovf;
    logic [NUM_CH*CNT_W-1:0] e_cnt;
    for (int c = 0; c < NUM_CH; c++) begin
      e_empty[c] = (q[c].size() == 0);
      e_ovf[c]   = m_ovf[c];
      e_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
    end
    chk("valid", 64'(packet_valid), 64'(m_valid));
    if (m_valid) begin
      chk("word", 64'(packet_word), 64'(m_word));
      chk("ch", 64'(packet_ch), 64'(m_ch));
    end
    chk("empty", 64'(fifo_empty), 64'(e_empty));
    chk("overflow", 64'(overflow), 64'(e_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(e_cnt));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    vld = '0; clr = '0; flush = 1'b0; rst = 1'b0; en = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0; ready = 1'b1;
    words = '0; vld = '0; clr = '0;
    m_valid = 1'b0; m_word = '0; m_ch = 0; m_last = NUM_CH - 1;
    for (int c = 0; c < NUM_CH; c++) begin m_ovf[c] = 1'b0; m_cnt[c] = 0; end

    #2;
    step(); step();
    chk("rst_valid", 64'(packet_valid), 64'd0);
    chk("rst_word", 64'(packet_word), 64'd0);
    chk("rst_ch", 64'(packet_ch), 64'd0);
    chk("rst_empty", 64'(fifo_empty), 64'hF);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_cnt", 64'(drop_cnt), 64'd0);
    rst = 1'b0;

    // single word latency
    words[0 +: WORD_W] = 32'hDEADBEEF; vld = 4'b0001;
    step();
    chk("t1_edge0_valid", 64'(packet_valid), 64'd0);
    vld = '0;
    step();
    chk("t1_valid", 64'(packet_valid), 64'd1);
    chk("t1_word", 64'(packet_word), 64'hDEADBEEF);
    chk("t1_ch", 64'(packet_ch), 64'd0);
    step();
    chk("t1_drain", 64'(packet_valid), 64'd0);

    // all channels at once from reset: RR order 0..3
    rst = 1'b1; step(); rst = 1'b0;
    for (int c = 0; c < NUM_CH; c++) words[c*WORD_W +: WORD_W] = $urandom;
    vld = 4'hF;
    step();
    vld = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      step();
      chk("t2_ch", 64'(packet_ch), 64'(i));
    end
    step();
    chk("t2_empty", 64'(fifo_empty), 64'hF);

    // ch1 overflow with stalled sink
    ready = 1'b0; words = '0; vld = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      words[1*WORD_W +: WORD_W] = 32'(i);
      step();
    end
    vld = '0;
    chk("t3_ovf", 64'(overflow[1]), 64'd1);
    chk("t3_cnt", 64'(drop_cnt[1*CNT_W +: CNT_W]), 64'd1);
    chk("t3_head", 64'(packet_word), 64'd0);
    ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("t3_word", 64'(packet_word), 64'(i));
      chk("t3_ch", 64'(packet_ch), 64'd1);
    end
    idle(2);

    // saturating counter on ch2, then clear-with-drop and plain clear
    ready = 1'b0; vld = 4'b0100;
    for (int i = 0; i < 309; i++) begin
      words[2*WORD_W +: WORD_W] = $urandom;
      step();
    end
    chk("t5_sat", 64'(drop_cnt[2*CNT_W +: CNT_W]), 64'd255);
    clr = 4'b0100;
    step();
    chk("t5_clr_drop_cnt", 64'(drop_cnt[2*CNT_W +: CNT_W]), 64'd1);
    chk("t5_clr_drop_ovf", 64'(overflow[2]), 64'd1);
    vld = '0;
    step();
    chk("t5_clr_cnt", 64'(drop_cnt[2*CNT_W +: CNT_W]), 64'd0);
    chk("t5_clr_ovf", 64'(overflow[2]), 64'd0);
    clr = '0; ready = 1'b1;
    idle(12);

    // flush with words buffered in ch0/ch3 and a held output
    ready = 1'b0; vld = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      words = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    vld = '0;
    step();
    flush = 1'b1; vld = 4'b1001;
    step();
    flush = 1'b0; vld = '0;
    chk("t6_valid", 64'(packet_valid), 64'd0);
    chk("t6_empty", 64'(fifo_empty), 64'hF);
    chk("t6_ovf", 64'(overflow), 64'h2);
    chk("t6_cnt", 64'(drop_cnt), 64'h100);

    // disabled inputs
    en = 1'b0; vld = 4'hF; ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      words = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    chk("t7_empty", 64'(fifo_empty), 64'hF);
    chk("t7_cnt", 64'(drop_cnt), 64'h100);
    idle(1);

    // held output while others push
    ready = 1'b0; vld = 4'b0001; words = {$urandom, $urandom, $urandom, $urandom};
    step();
    vld = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      words = {$urandom, $urandom, $urandom, $urandom};
      step();
      chk("t4_hold_ch", 64'(packet_ch), 64'd0);
    end
    vld = '0; ready = 1'b1;
    step();
    chk("t4_next_ch", 64'(packet_ch), 64'd1);
    idle(20);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 999) == 0);
      flush = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 9) != 0);
      ready = ($urandom_range(0, 9) < 6);
      vld   = NUM_CH'($urandom);
      clr   = '0;
      for (int c = 0; c < NUM_CH; c++) clr[c] = ($urandom_range(0, 31) == 0);
      words = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
